// File: rtl/lcd_cmd_seq.sv
// LCD command sequencer: on start, fetches a 4-bit command script from a synchronous
// ROM and issues each command to the image controller under its busy handshake.
module lcd_cmd_seq #(
  parameter int CROM_AW = 6,
  parameter int CMD_W   = 4,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CMD_W-1:0]   CROM_Q,
  output logic               CROM_rd,
  output logic [CROM_AW-1:0] CROM_A,
  input  logic               busy,
  input  logic               done,
  output logic [CMD_W-1:0]   cmd,
  output logic               cmd_valid,
  output logic               seq_busy,
  output logic               seq_done,
  output logic [CNT_W-1:0]   cmd_cnt,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_LATCH     = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FIN       = 3'd5
  } state_e;

  localparam logic [CROM_AW-1:0] ADDR_LAST = {CROM_AW{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  function automatic logic is_illegal(input logic [CMD_W-1:0] code);
    return code >= CMD_W'(12);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  state_e               state_q, state_d;
  logic [CROM_AW-1:0]   addr_q, addr_d;
  logic [CMD_W-1:0]     cmd_r_q, cmd_r_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 force_term_q, force_term_d;
  logic [CMD_W-1:0]     cmd_out_q, cmd_out_d;
  logic                 crom_rd_q, crom_rd_d;
  logic [CROM_AW-1:0]   crom_a_q, crom_a_d;
  logic                 seq_busy_q, seq_busy_d;
  logic                 seq_done_q, seq_done_d;

  // State and datapath registers; reset aborts any run in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      cmd_r_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      force_term_q <= 1'b0;
      cmd_out_q    <= '0;
      crom_rd_q    <= 1'b0;
      crom_a_q     <= '0;
      seq_busy_q   <= 1'b0;
      seq_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cmd_r_q      <= cmd_r_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      force_term_q <= force_term_d;
      cmd_out_q    <= cmd_out_d;
      crom_rd_q    <= crom_rd_d;
      crom_a_q     <= crom_a_d;
      seq_busy_q   <= seq_busy_d;
      seq_done_q   <= seq_done_d;
    end
  end

  // Next-state and datapath update rules.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    cmd_r_d      = cmd_r_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    force_term_d = force_term_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d       = '0;
          cnt_d        = '0;
          err_d        = 1'b0;
          force_term_d = 1'b0;
          state_d      = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        cmd_r_d = CROM_Q;
        if (is_illegal(CROM_Q)) begin
          err_d = 1'b1;
          if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + CROM_AW'(1);
            state_d = S_FETCH;
          end else begin
            cmd_r_d      = '0;
            force_term_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!busy) begin
          cnt_d = sat_inc(cnt_q);
          if (cmd_r_q == '0) begin
            state_d = S_WAIT_DONE;
          end else if (addr_q != ADDR_LAST) begin
            addr_d  = addr_q + CROM_AW'(1);
            state_d = S_FETCH;
          end else begin
            // Script ran off the end without a terminator: issue a forced 0 next.
            err_d        = 1'b1;
            cmd_r_d      = '0;
            force_term_d = 1'b1;
            state_d      = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (done) begin
          state_d = S_FIN;
        end else begin
          state_d = S_WAIT_DONE;
        end
      end
      S_FIN:   state_d = S_FIN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: strobe is combinational, everything else is registered from next state.
  always_comb begin
    cmd_valid  = (state_q == S_ISSUE) && !busy;
    crom_rd_d  = (state_d == S_FETCH);
    crom_a_d   = (state_d == S_FETCH) ? addr_d : crom_a_q;
    cmd_out_d  = (state_d == S_ISSUE) ? cmd_r_d : cmd_out_q;
    seq_busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    seq_done_d = (state_d == S_FIN);
  end

  assign CROM_rd  = crom_rd_q;
  assign CROM_A   = crom_a_q;
  assign cmd      = cmd_out_q;
  assign seq_busy = seq_busy_q;
  assign seq_done = seq_done_q;
  assign cmd_cnt  = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_lcd_cmd_seq.sv
// Self-checking bench for lcd_cmd_seq: table vectors, hand-written corner sequences
// and randomized scripts compared against a script-walking reference model.
module tb_lcd_cmd_seq;
  logic       clk = 1'b0;
  logic       reset, start, busy, done;
  logic [3:0] crom_q;
  logic       crom_rd;
  logic [5:0] crom_a;
  logic [3:0] cmd;
  logic       cmd_valid, seq_busy, seq_done, err;
  logic [6:0] cmd_cnt;
  logic [3:0] rom [64];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int s_cyc   = 0;
  bit zero_seen = 1'b0;
  int got_q[$];
  int got_cyc[$];
  int exp_q[$];
  bit exp_err;

  typedef struct {
    logic [15:0] head;
    int          head_len;
    logic [3:0]  fill;
    int          exp_cnt;
    logic        exp_err;
  } vec_t;
  vec_t vecs [7];

  lcd_cmd_seq dut (
    .clk(clk), .reset(reset), .start(start), .CROM_Q(crom_q), .CROM_rd(crom_rd),
    .CROM_A(crom_a), .busy(busy), .done(done), .cmd(cmd), .cmd_valid(cmd_valid),
    .seq_busy(seq_busy), .seq_done(seq_done), .cmd_cnt(cmd_cnt), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (crom_rd) crom_q <= rom[crom_a];
  end

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (crom_rd) rd_cnt = rd_cnt + 1;
      if (cmd_valid) begin
        got_q.push_back(int'(cmd));
        got_cyc.push_back(cyc);
        if (cmd == 4'd0) zero_seen = 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse_start();
    got_q.delete(); got_cyc.delete(); zero_seen = 1'b0;
    start = 1'b1; s_cyc = cyc;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_zero(input int busy_pct);
    for (int i = 0; i < 3000 && !zero_seen; i++) begin
      busy = ($urandom_range(0, 99) < busy_pct);
      @(posedge clk); #1;
    end
    busy = 1'b0;
    chk("terminator_seen", zero_seen, 1);
  endtask

  task automatic finish_run();
    chk("wait_seq_busy", seq_busy, 1);
    chk("wait_seq_done", seq_done, 0);
    done = 1'b1;
    @(posedge clk); #1 done = 1'b0;
    chk("fin_seq_done", seq_done, 1);
    chk("fin_seq_busy", seq_busy, 0);
  endtask

  // Walk the script as the controller should see it: legal codes are issued,
  // illegal ones skipped, and a 0 is forced if the script never terminates.
  task automatic model();
    int c;
    exp_q.delete(); exp_err = 1'b0;
    for (int a = 0; a < 64; a++) begin
      c = int'(rom[a]);
      if (c >= 12) begin
        exp_err = 1'b1;
        if (a == 63) exp_q.push_back(0);
      end else begin
        exp_q.push_back(c);
        if (c == 0) break;
        if (a == 63) begin
          exp_err = 1'b1;
          exp_q.push_back(0);
        end
      end
    end
  endtask

  task automatic load_rom(input logic [15:0] head, input int len, input logic [3:0] fill);
    for (int a = 0; a < 64; a++) rom[a] = (a < len) ? head[4*a +: 4] : fill;
  endtask

  initial begin
    vecs[0] = '{16'h0051, 3, 4'd0,  3,  1'b0};
    vecs[1] = '{16'h00D2, 3, 4'd0,  2,  1'b1};
    vecs[2] = '{16'h0000, 0, 4'd3,  65, 1'b1};
    vecs[3] = '{16'h0000, 0, 4'd12, 1,  1'b1};
    vecs[4] = '{16'h0000, 1, 4'd5,  1,  1'b0};
    vecs[5] = '{16'h4444, 4, 4'd15, 5,  1'b1};
    vecs[6] = '{16'h00AB, 2, 4'd12, 3,  1'b1};

    reset = 1'b0; start = 1'b0; busy = 1'b0; done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_crom_rd", crom_rd, 0);
    chk("rst_crom_a", crom_a, 0);
    chk("rst_cmd", cmd, 0);
    chk("rst_seq_busy", seq_busy, 0);
    chk("rst_seq_done", seq_done, 0);
    chk("rst_cmd_cnt", cmd_cnt, 0);
    chk("rst_err", err, 0);
    reset = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      load_rom(vecs[v].head, vecs[v].head_len, vecs[v].fill);
      pulse_start();
      wait_zero(25);
      chk("tbl_strobes", got_q.size(), vecs[v].exp_cnt);
      chk("tbl_cmd_cnt", cmd_cnt, vecs[v].exp_cnt);
      chk("tbl_err", err, vecs[v].exp_err);
      if (got_q.size() > 0) chk("tbl_last_cmd", got_q[got_q.size()-1], 0);
      foreach (got_q[i]) chk("tbl_no_illegal", got_q[i] >= 12, 0);
      finish_run();
    end

    // Latency and spacing with busy low, then start ignored in WAIT_DONE and FIN.
    do_reset();
    load_rom(16'h0051, 3, 4'd0);
    pulse_start();
    wait_zero(0);
    chk("lat_strobes", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("lat_cmd0", got_q[0], 1);
      chk("lat_cmd1", got_q[1], 5);
      chk("lat_cmd2", got_q[2], 0);
      chk("lat_first", got_cyc[0] - s_cyc, 3);
      chk("lat_space1", got_cyc[1] - got_cyc[0], 3);
      chk("lat_space2", got_cyc[2] - got_cyc[1], 3);
    end
    rd_cnt = 0;
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("wd_start_rd", rd_cnt, 0);
    chk("wd_start_cnt", cmd_cnt, 3);
    finish_run();
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("fin_start_rd", rd_cnt, 0);
    chk("fin_start_cnt", cmd_cnt, 3);
    chk("fin_start_done", seq_done, 1);

    // Busy held for 10 cycles on the first ISSUE.
    do_reset();
    load_rom(16'h0007, 2, 4'd0);
    busy = 1'b1;
    pulse_start();
    repeat (2) begin @(posedge clk); #1; end
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      chk("busy_hold_valid", cmd_valid, 0);
      chk("busy_hold_cmd", cmd, 7);
      @(posedge clk); #1;
    end
    busy = 1'b0;
    @(negedge clk);
    chk("busy_release_valid", cmd_valid, 1);
    chk("busy_release_cmd", cmd, 7);
    wait_zero(0);
    chk("busy_strobes", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("busy_cmd0", got_q[0], 7);
      chk("busy_cmd1", got_q[1], 0);
    end
    chk("busy_cnt", cmd_cnt, 2);

    // Asynchronous reset while stalled in ISSUE after an error.
    do_reset();
    load_rom(16'h09E, 3, 4'd0);
    busy = 1'b1;
    pulse_start();
    repeat (6) begin @(posedge clk); #1; end
    chk("pre_rst_err", err, 1);
    chk("pre_rst_cmd", cmd, 9);
    chk("pre_rst_busy", seq_busy, 1);
    reset = 1'b0;
    #1;
    chk("arst_cmd_valid", cmd_valid, 0);
    chk("arst_cmd", cmd, 0);
    chk("arst_crom_a", crom_a, 0);
    chk("arst_crom_rd", crom_rd, 0);
    chk("arst_seq_busy", seq_busy, 0);
    chk("arst_err", err, 0);
    chk("arst_cnt", cmd_cnt, 0);
    busy = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    load_rom(16'h0006, 2, 4'd0);
    pulse_start();
    chk("rerun_crom_rd", crom_rd, 1);
    chk("rerun_crom_a", crom_a, 0);
    chk("rerun_err", err, 0);
    wait_zero(0);
    chk("rerun_cnt", cmd_cnt, 2);
    finish_run();

    // Randomized scripts against the reference model.
    for (int r = 0; r < 12; r++) begin
      bit no_term;
      int p;
      no_term = ($urandom_range(0, 3) == 0);
      for (int a = 0; a < 64; a++) begin
        p = $urandom_range(0, 99);
        if (p < 4 && !no_term) rom[a] = 4'd0;
        else if (p < 14) rom[a] = 4'(12 + $urandom_range(0, 3));
        else rom[a] = 4'($urandom_range(1, 11));
      end
      model();
      do_reset();
      pulse_start();
      wait_zero(30);
      chk("rnd_strobes", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("rnd_cmd", got_q[i], exp_q[i]);
      chk("rnd_cnt", cmd_cnt, exp_q.size());
      chk("rnd_err", err, exp_err);
      finish_run();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_seq.md
Name: lcd_cmd_seq

Overview:
Upstream command sequencer for the LCD image controller. On a start pulse it fetches a script of 4-bit commands from a synchronous command ROM. It issues each command on cmd/cmd_valid only while the controller's busy is low, and stops after issuing the write command (0). It then waits for the controller's done, reports completion, and flags malformed scripts.

Parameters:
CROM_AW, 6, command ROM address width (script depth 2^CROM_AW = 64)
CMD_W, 4, command width
CNT_W, 7, width of issued-command counter (holds up to 2^CROM_AW + 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to run the script; sampled only in IDLE
CROM_Q  input  CMD_W  command ROM data, valid the cycle after CROM_rd/CROM_A
CROM_rd  output  1  command ROM read enable
CROM_A  output  CROM_AW  command ROM address
busy  input  1  controller busy; commands are accepted only when low
done  input  1  controller finished writing the image
cmd  output  CMD_W  command to controller
cmd_valid  output  1  command strobe
seq_busy  output  1  high in every state except IDLE and FIN
seq_done  output  1  high in FIN
cmd_cnt  output  CNT_W  number of commands issued since start
err  output  1  sticky script-error flag, cleared on start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, addr=0, cmd=0, cmd_valid=0, CROM_rd=0, CROM_A=0, seq_busy=0, seq_done=0, cmd_cnt=0, err=0, force_term=0. Reset mid-operation aborts immediately. No partial state survives.
- States: IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, FIN.
- IDLE: on start=1, clear addr, cmd_cnt, err and force_term, then go to FETCH. start is ignored in all other states.
- FETCH (1 cycle): CROM_rd=1, CROM_A=addr, then go to LATCH. CROM_rd is 0 in all other states. CROM_A holds its last value outside FETCH.
- LATCH (1 cycle): cmd_r <= CROM_Q. Codes 12..15 are illegal:
  - set err;
  - if addr != 63, addr++ and go to FETCH (command not issued);
  - if addr == 63, load cmd_r = 0, set force_term, and go to ISSUE.
  - Otherwise go to ISSUE.
- ISSUE: cmd = cmd_r, held stable throughout the state. cmd_valid = (state==ISSUE) && !busy, decoded combinationally. The command is considered delivered on the rising edge where cmd_valid=1, and that edge also increments cmd_cnt. Transitions on that edge:
  - cmd_r == 0 goes to WAIT_DONE;
  - cmd_r != 0 and addr != 63: addr++, go to FETCH;
  - cmd_r != 0 and addr == 63 (script missing a terminator): set err, load cmd_r = 0, set force_term, stay in ISSUE so a forced 0 is issued next.
  - While busy=1, stay in ISSUE with cmd_valid=0 and cmd held.
- WAIT_DONE: cmd_valid=0. When done=1, go to FIN.
- FIN: seq_done=1, seq_busy=0. Stay until reset.
- Minimum spacing between cmd_valid pulses is 3 cycles (FETCH, LATCH, ISSUE). Latency from start to the first cmd_valid is 3 cycles when busy is low.
- cmd_cnt saturates at 2^CNT_W-1 (unreachable with the default parameters). Maximum value is 65 (64 script entries plus a forced terminator).
- cmd is registered and holds its last value outside ISSUE. cmd_valid is never asserted outside ISSUE.

Test Plan:
- ROM[0..2]={1,5,0}, busy=0, pulse start → cmd_valid pulses carrying 1, 5, 0, with the first pulse 3 cycles after start and 3-cycle spacing. cmd_cnt=3, state WAIT_DONE. Pulse done → seq_done=1, seq_busy=0 next cycle.
- ROM={7,0}, busy held 1 for 10 cycles upon entering the first ISSUE → cmd_valid=0 and cmd=7 held. cmd_valid=1 on the first cycle after busy falls, then cmd 0 is issued, cmd_cnt=2.
- ROM={2,13,0} → cmd_valid carries only 2 and 0 (13 never strobed). err=1, cmd_cnt=2, run completes normally after done.
- ROM all 3 (no 0) → 64 strobes of cmd=3, then one strobe of cmd=0. cmd_cnt=65, err=1, then WAIT_DONE.
- reset driven 0 while in ISSUE with busy=1 → all outputs 0 asynchronously. After release, start reruns from CROM_A=0 with err=0.
- start pulsed during WAIT_DONE and during FIN → no effect: no CROM_rd, cmd_cnt unchanged.
